plic_apb_mem_bridge: RTL and testbench

//   APB completer that initiates the PLIC register-file memory port (csb/rwb/wm/wdata -> rdata/error).

---
 rtl/plic_apb_mem_bridge_if.sv | 47 ++++
 rtl/plic_apb_mem_bridge.sv | 111 +++++++++++
 tb/tb_plic_apb_mem_bridge.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/plic_apb_mem_bridge_if.sv
// plic_apb_mem_bridge_if: APB completer, memory-port and access-attribute bundle for plic_apb_mem_bridge
interface plic_apb_mem_bridge_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int NUM_DOMAIN     = 16,
  parameter int DOMAIN_W       = (NUM_DOMAIN > 1) ? $clog2(NUM_DOMAIN) : 1
);
  logic                      psel_i;
  logic                      penable_i;
  logic                      pwrite_i;
  logic [ADDR_WIDTH-1:0]     paddr_i;
  logic [DATA_WIDTH-1:0]     pwdata_i;
  logic [DATA_WIDTH/8-1:0]   pstrb_i;
  logic [2:0]                pprot_i;
  logic [1:0]                priv_mode_i;
  logic [DOMAIN_W-1:0]       did_i;
  logic                      pready_o;
  logic [DATA_WIDTH-1:0]     prdata_o;
  logic                      pslverr_o;
  logic                      mem_csb_o;
  logic                      mem_rwb_o;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH/8-1:0]   mem_wm_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;
  logic                      mem_error_i;
  logic                      pri_acc_o;
  logic                      sec_acc_o;
  logic                      data_acc_o;
  logic [1:0]                acc_priv_mode_o;
  logic [DOMAIN_W-1:0]       acc_did_o;
  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, pprot_i, priv_mode_i, did_i,
    input  mem_rdata_i, mem_error_i,
    output pready_o, prdata_o, pslverr_o,
    output mem_csb_o, mem_rwb_o, mem_addr_o, mem_wm_o, mem_wdata_o,
    output pri_acc_o, sec_acc_o, data_acc_o, acc_priv_mode_o, acc_did_o
  );
  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i, pprot_i, priv_mode_i, did_i,
    output mem_rdata_i, mem_error_i,
    input  pready_o, prdata_o, pslverr_o,
    input  mem_csb_o, mem_rwb_o, mem_addr_o, mem_wm_o, mem_wdata_o,
    input  pri_acc_o, sec_acc_o, data_acc_o, acc_priv_mode_o, acc_did_o
  );
endinterface

// File: rtl/plic_apb_mem_bridge.sv
// plic_apb_mem_bridge: APB completer turning each transfer into one memory strobe (optional PLIC_BRIDGE_ADDR_CHK_EN address check)
module plic_apb_mem_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 26,
  parameter int NUM_DOMAIN     = 16,
  parameter int DOMAIN_W       = (NUM_DOMAIN > 1) ? $clog2(NUM_DOMAIN) : 1
) (
  input logic                  pclk_i,
  input logic                  prst_n_i,
  plic_apb_mem_bridge_if.slave bus
);
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;
  state_t                    state_q, state_d;
  logic                      csb_q, csb_d;
  logic                      rwb_q, rwb_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SW-1:0]             wm_q, wm_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      pri_q, pri_d;
  logic                      sec_q, sec_d;
  logic                      dacc_q, dacc_d;
  logic [1:0]                pm_q, pm_d;
  logic [DOMAIN_W-1:0]       did_q, did_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      ready_q, ready_d;
  logic                      bad_q, bad_d;
  logic                      start;
  logic                      unused_ok;
  assign start     = (state_q == ST_IDLE) && bus.psel_i;
  assign unused_ok = ^{bus.penable_i, bus.paddr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};
  // State and output registers; reset drops any in-flight strobe or response
  always_ff @(posedge pclk_i) begin
    if (!prst_n_i) begin
      state_q <= ST_IDLE;
      csb_q   <= 1'b1;
      rwb_q   <= 1'b0;
      addr_q  <= '0;
      wm_q    <= '0;
      wdata_q <= '0;
      pri_q   <= 1'b0;
      sec_q   <= 1'b0;
      dacc_q  <= 1'b0;
      pm_q    <= '0;
      did_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      rwb_q   <= rwb_d;
      addr_q  <= addr_d;
      wm_q    <= wm_d;
      wdata_q <= wdata_d;
      pri_q   <= pri_d;
      sec_q   <= sec_d;
      dacc_q  <= dacc_d;
      pm_q    <= pm_d;
      did_q   <= did_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      bad_q   <= bad_d;
    end
  end
  // Fixed four-cycle walk; only IDLE looks at psel
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (bus.psel_i ? ST_REQ : ST_IDLE) :
              (state_q == ST_REQ)  ? ST_WAIT :
              (state_q == ST_WAIT) ? ST_DONE : ST_IDLE;
  end
  // Next register values: latch request in IDLE, strobe in REQ, capture response in WAIT, ready in DONE
  always_comb begin
`ifdef PLIC_BRIDGE_ADDR_CHK_EN
    bad_d   = start ? ((bus.paddr_i[1:0] != 2'b00) ||
                       (bus.paddr_i[ADDR_WIDTH-1:MEM_ADDR_WIDTH] != '0)) : bad_q;
`else
    bad_d   = 1'b0;
`endif
    csb_d   = !(start && !bad_d);
    rwb_d   = start ? bus.pwrite_i : rwb_q;
    addr_d  = start ? bus.paddr_i[MEM_ADDR_WIDTH-1:0] : addr_q;
    wm_d    = start ? (bus.pwrite_i ? bus.pstrb_i : '0) : wm_q;
    wdata_d = start ? bus.pwdata_i : wdata_q;
    pri_d   = start ? bus.pprot_i[0] : pri_q;
    sec_d   = start ? !bus.pprot_i[1] : sec_q;
    dacc_d  = start ? !bus.pprot_i[2] : dacc_q;
    pm_d    = start ? bus.priv_mode_i : pm_q;
    did_d   = start ? bus.did_i : did_q;
    ready_d = (state_q == ST_WAIT);
    rdata_d = (state_q == ST_WAIT && !rwb_q && !bad_q) ? bus.mem_rdata_i : '0;
    err_d   = (state_q == ST_WAIT) && (bad_q || bus.mem_error_i);
  end
  assign bus.pready_o        = ready_q;
  assign bus.prdata_o        = rdata_q;
  assign bus.pslverr_o       = err_q;
  assign bus.mem_csb_o       = csb_q;
  assign bus.mem_rwb_o       = rwb_q;
  assign bus.mem_addr_o      = addr_q;
  assign bus.mem_wm_o        = wm_q;
  assign bus.mem_wdata_o     = wdata_q;
  assign bus.pri_acc_o       = pri_q;
  assign bus.sec_acc_o       = sec_q;
  assign bus.data_acc_o      = dacc_q;
  assign bus.acc_priv_mode_o = pm_q;
  assign bus.acc_did_o       = did_q;
endmodule

// File: tb/tb_plic_apb_mem_bridge.sv
// tb_plic_apb_mem_bridge: directed self-checking bench for plic_apb_mem_bridge
module tb_plic_apb_mem_bridge;
  logic clk = 1'b0;
  logic prst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   strobes = 0;
  always #5 clk = ~clk;
  plic_apb_mem_bridge_if intf ();
  plic_apb_mem_bridge dut (.pclk_i(clk), .prst_n_i(prst_n), .bus(intf));
  always @(posedge clk) if (intf.mem_csb_o === 1'b0) strobes++;
  typedef struct {
    logic [3:0]  csb;
    logic [3:0]  rdy;
    logic        rwb;
    logic [25:0] addr;
    logic [3:0]  wm;
    logic [31:0] wdata;
    logic [2:0]  acc;
    logic [1:0]  pm;
    logic [3:0]  did;
    logic [31:0] prdata;
    logic        err;
    logic [31:0] prdata_idle;
    logic        err_idle;
    int          nstrobe;
  } obs_t;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // One full transfer; inputs are scrambled after the setup edge to prove they are ignored
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, input logic [1:0] pm, input logic [3:0] d,
                      input logic [31:0] rd, input logic er, input bit hold, output obs_t o);
    int s0;
    s0 = strobes;
    intf.psel_i = 1'b1; intf.penable_i = 1'b0; intf.pwrite_i = w; intf.paddr_i = a;
    intf.pwdata_i = wd; intf.pstrb_i = st; intf.pprot_i = pr; intf.priv_mode_i = pm; intf.did_i = d;
    tick;
    o.csb[3] = intf.mem_csb_o; o.rdy[3] = intf.pready_o;
    o.rwb = intf.mem_rwb_o; o.addr = intf.mem_addr_o; o.wm = intf.mem_wm_o; o.wdata = intf.mem_wdata_o;
    o.acc = {intf.pri_acc_o, intf.sec_acc_o, intf.data_acc_o};
    o.pm = intf.acc_priv_mode_o; o.did = intf.acc_did_o;
    intf.penable_i = 1'b1; intf.pwrite_i = ~w; intf.paddr_i = ~a; intf.pwdata_i = ~wd;
    intf.pstrb_i = ~st; intf.pprot_i = ~pr; intf.priv_mode_i = ~pm; intf.did_i = ~d;
    intf.mem_rdata_i = 32'hDEAD_BEEF; intf.mem_error_i = ~er;
    tick;
    o.csb[2] = intf.mem_csb_o; o.rdy[2] = intf.pready_o;
    intf.mem_rdata_i = rd; intf.mem_error_i = er;
    tick;
    o.csb[1] = intf.mem_csb_o; o.rdy[1] = intf.pready_o;
    o.prdata = intf.prdata_o; o.err = intf.pslverr_o;
    intf.mem_rdata_i = 32'h0BAD_F00D; intf.mem_error_i = 1'b1;
    if (!hold) begin intf.psel_i = 1'b0; intf.penable_i = 1'b0; end
    tick;
    o.csb[0] = intf.mem_csb_o; o.rdy[0] = intf.pready_o;
    o.prdata_idle = intf.prdata_o; o.err_idle = intf.pslverr_o;
    intf.mem_error_i = 1'b0;
    o.nstrobe = strobes - s0;
  endtask
  task automatic test_reset;
    intf.psel_i = 1'b1; intf.penable_i = 1'b0; intf.pwrite_i = 1'b1; intf.paddr_i = 32'h8;
    intf.pwdata_i = 32'h1; intf.pstrb_i = 4'hF; intf.pprot_i = 3'b000; intf.priv_mode_i = 2'b11;
    intf.did_i = 4'h1; intf.mem_rdata_i = 32'h0; intf.mem_error_i = 1'b0;
    prst_n = 1'b0;
    tick; tick; tick;
    checks++;
    if ({intf.mem_csb_o, intf.pready_o, intf.pslverr_o, intf.mem_rwb_o} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: got %b exp 1000", {intf.mem_csb_o, intf.pready_o, intf.pslverr_o, intf.mem_rwb_o});
    end
    checks++;
    if ({intf.prdata_o, intf.mem_wdata_o, intf.mem_addr_o, intf.mem_wm_o} !== 94'h0) begin
      errors++; $display("FAIL reset_data: got %h exp 0", {intf.prdata_o, intf.mem_wdata_o, intf.mem_addr_o, intf.mem_wm_o});
    end
    checks++;
    if ({intf.pri_acc_o, intf.sec_acc_o, intf.data_acc_o, intf.acc_priv_mode_o, intf.acc_did_o} !== 9'h0) begin
      errors++; $display("FAIL reset_attr: got %h exp 0", {intf.pri_acc_o, intf.sec_acc_o, intf.data_acc_o, intf.acc_priv_mode_o, intf.acc_did_o});
    end
    intf.psel_i = 1'b0;
    prst_n = 1'b1;
    tick;
  endtask
  task automatic test_write;
    obs_t o;
    xfer(1'b1, 32'h4, 32'h7, 4'hF, 3'b001, 2'b11, 4'h3, 32'h0, 1'b0, 1'b0, o);
    checks++;
    if (o.csb !== 4'b0111) begin errors++; $display("FAIL wr_csb: got %b exp 0111", o.csb); end
    checks++;
    if (o.nstrobe !== 1) begin errors++; $display("FAIL wr_nstrobe: got %0d exp 1", o.nstrobe); end
    checks++;
    if ({o.rwb, o.addr, o.wm, o.wdata} !== {1'b1, 26'h4, 4'hF, 32'h7}) begin
      errors++; $display("FAIL wr_req: got %h exp %h", {o.rwb, o.addr, o.wm, o.wdata}, {1'b1, 26'h4, 4'hF, 32'h7});
    end
    checks++;
    if ({o.acc, o.pm, o.did} !== {3'b111, 2'b11, 4'h3}) begin
      errors++; $display("FAIL wr_attr: got %h exp %h", {o.acc, o.pm, o.did}, {3'b111, 2'b11, 4'h3});
    end
    checks++;
    if (o.rdy !== 4'b0010) begin errors++; $display("FAIL wr_ready: got %b exp 0010", o.rdy); end
    checks++;
    if ({o.err, o.prdata} !== 33'h0) begin errors++; $display("FAIL wr_resp: got %h exp 0", {o.err, o.prdata}); end
    checks++;
    if ({intf.mem_addr_o, intf.mem_wdata_o} !== {26'h4, 32'h7}) begin
      errors++; $display("FAIL wr_hold: got %h exp %h", {intf.mem_addr_o, intf.mem_wdata_o}, {26'h4, 32'h7});
    end
  endtask
  task automatic test_read;
    obs_t o;
    xfer(1'b0, 32'h1000, 32'h55, 4'hF, 3'b010, 2'b11, 4'h2, 32'hA5A5_0001, 1'b0, 1'b0, o);
    checks++;
    if (o.csb !== 4'b0111) begin errors++; $display("FAIL rd_csb: got %b exp 0111", o.csb); end
    checks++;
    if ({o.rwb, o.addr, o.wm} !== {1'b0, 26'h1000, 4'h0}) begin
      errors++; $display("FAIL rd_req: got %h exp %h", {o.rwb, o.addr, o.wm}, {1'b0, 26'h1000, 4'h0});
    end
    checks++;
    if (o.acc !== 3'b001) begin errors++; $display("FAIL rd_attr: got %b exp 001", o.acc); end
    checks++;
    if (o.rdy !== 4'b0010) begin errors++; $display("FAIL rd_ready: got %b exp 0010", o.rdy); end
    checks++;
    if ({o.err, o.prdata} !== {1'b0, 32'hA5A5_0001}) begin
      errors++; $display("FAIL rd_data: got %h exp %h", {o.err, o.prdata}, {1'b0, 32'hA5A5_0001});
    end
    checks++;
    if ({o.err_idle, o.prdata_idle} !== 33'h0) begin
      errors++; $display("FAIL rd_clear: got %h exp 0", {o.err_idle, o.prdata_idle});
    end
  endtask
  task automatic test_error;
    obs_t o;
    xfer(1'b1, 32'h0020_0FFC, 32'h1, 4'h3, 3'b110, 2'b01, 4'h5, 32'h0, 1'b1, 1'b0, o);
    checks++;
    if (o.nstrobe !== 1) begin errors++; $display("FAIL err_nstrobe: got %0d exp 1", o.nstrobe); end
    checks++;
    if ({o.addr, o.wm, o.acc, o.pm, o.did} !== {26'h20_0FFC, 4'h3, 3'b000, 2'b01, 4'h5}) begin
      errors++; $display("FAIL err_req: got %h exp %h", {o.addr, o.wm, o.acc, o.pm, o.did}, {26'h20_0FFC, 4'h3, 3'b000, 2'b01, 4'h5});
    end
    checks++;
    if ({o.rdy[1], o.err, o.prdata} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL err_resp: got %h exp %h", {o.rdy[1], o.err, o.prdata}, {1'b1, 1'b1, 32'h0});
    end
    checks++;
    if (o.err_idle !== 1'b0) begin errors++; $display("FAIL err_clear: got %b exp 0", o.err_idle); end
  endtask
  task automatic test_back_to_back;
    obs_t o;
    logic [31:0] val [3];
    int s0;
    val[0] = 32'h1111_0001; val[1] = 32'h2222_0002; val[2] = 32'h3333_0003;
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 32'h100 + 32'(i) * 4, 32'h0, 4'hF, 3'b000, 2'b11, 4'h0, val[i], 1'b0, i < 2, o);
      checks++;
      if ({o.csb, o.rdy} !== 8'b0111_0010) begin
        errors++; $display("FAIL b2b_seq%0d: got %b exp 01110010", i, {o.csb, o.rdy});
      end
      checks++;
      if ({o.addr, o.prdata} !== {26'h100 + 26'(i) * 4, val[i]}) begin
        errors++; $display("FAIL b2b_data%0d: got %h exp %h", i, {o.addr, o.prdata}, {26'h100 + 26'(i) * 4, val[i]});
      end
    end
    checks++;
    if (strobes - s0 !== 3) begin errors++; $display("FAIL b2b_nstrobe: got %0d exp 3", strobes - s0); end
    tick;
    checks++;
    if ({intf.mem_csb_o, intf.pready_o} !== 2'b10) begin
      errors++; $display("FAIL b2b_stop: got %b exp 10", {intf.mem_csb_o, intf.pready_o});
    end
  endtask
  task automatic test_addr;
    obs_t o;
`ifdef PLIC_BRIDGE_ADDR_CHK_EN
    xfer(1'b0, 32'h0000_0006, 32'h0, 4'hF, 3'b000, 2'b11, 4'h0, 32'h7777_7777, 1'b0, 1'b0, o);
    checks++;
    if ({o.nstrobe[1:0], o.csb} !== {2'd0, 4'b1111}) begin
      errors++; $display("FAIL chk_lo_strobe: got %h exp 0f", {o.nstrobe[1:0], o.csb});
    end
    checks++;
    if ({o.rdy[1], o.err, o.prdata} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL chk_lo_resp: got %h exp %h", {o.rdy[1], o.err, o.prdata}, {1'b1, 1'b1, 32'h0});
    end
    xfer(1'b0, 32'h0400_0000, 32'h0, 4'hF, 3'b000, 2'b11, 4'h0, 32'h7777_7777, 1'b0, 1'b0, o);
    checks++;
    if ({o.nstrobe[1:0], o.csb} !== {2'd0, 4'b1111}) begin
      errors++; $display("FAIL chk_hi_strobe: got %h exp 0f", {o.nstrobe[1:0], o.csb});
    end
    checks++;
    if ({o.rdy[1], o.err, o.prdata} !== {1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL chk_hi_resp: got %h exp %h", {o.rdy[1], o.err, o.prdata}, {1'b1, 1'b1, 32'h0});
    end
`else
    xfer(1'b0, 32'h0000_0006, 32'h0, 4'hF, 3'b000, 2'b11, 4'h0, 32'h7777_7777, 1'b0, 1'b0, o);
    checks++;
    if ({o.csb, o.addr} !== {4'b0111, 26'h6}) begin
      errors++; $display("FAIL pass_lo_req: got %h exp %h", {o.csb, o.addr}, {4'b0111, 26'h6});
    end
    checks++;
    if ({o.rdy[1], o.err, o.prdata} !== {1'b1, 1'b0, 32'h7777_7777}) begin
      errors++; $display("FAIL pass_lo_resp: got %h exp %h", {o.rdy[1], o.err, o.prdata}, {1'b1, 1'b0, 32'h7777_7777});
    end
    xfer(1'b0, 32'h0400_0000, 32'h0, 4'hF, 3'b000, 2'b11, 4'h0, 32'h7777_7777, 1'b0, 1'b0, o);
    checks++;
    if ({o.csb, o.addr} !== {4'b0111, 26'h0}) begin
      errors++; $display("FAIL pass_hi_req: got %h exp %h", {o.csb, o.addr}, {4'b0111, 26'h0});
    end
    checks++;
    if ({o.rdy[1], o.err, o.prdata} !== {1'b1, 1'b0, 32'h7777_7777}) begin
      errors++; $display("FAIL pass_hi_resp: got %h exp %h", {o.rdy[1], o.err, o.prdata}, {1'b1, 1'b0, 32'h7777_7777});
    end
`endif
  endtask
  task automatic test_reset_mid;
    int rdy_seen, csb_seen;
    intf.psel_i = 1'b1; intf.penable_i = 1'b0; intf.pwrite_i = 1'b1; intf.paddr_i = 32'h40;
    intf.pwdata_i = 32'h9; intf.pstrb_i = 4'hF; intf.pprot_i = 3'b000; intf.priv_mode_i = 2'b11; intf.did_i = 4'h7;
    tick;
    checks++;
    if (intf.mem_csb_o !== 1'b0) begin errors++; $display("FAIL mid_req_csb: got %b exp 0", intf.mem_csb_o); end
    prst_n = 1'b0;
    intf.psel_i = 1'b0;
    tick;
    checks++;
    if ({intf.mem_csb_o, intf.pready_o, intf.mem_addr_o} !== {1'b1, 1'b0, 26'h0}) begin
      errors++; $display("FAIL mid_reset: got %h exp %h", {intf.mem_csb_o, intf.pready_o, intf.mem_addr_o}, {1'b1, 1'b0, 26'h0});
    end
    prst_n = 1'b1;
    rdy_seen = 0; csb_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (intf.pready_o === 1'b1) rdy_seen++;
      if (intf.mem_csb_o !== 1'b1) csb_seen++;
    end
    checks++;
    if ({rdy_seen, csb_seen} !== 64'h0) begin
      errors++; $display("FAIL mid_dropped: got ready=%0d strobe=%0d exp 0 0", rdy_seen, csb_seen);
    end
  endtask
  initial begin
    test_reset;
    test_write;
    test_read;
    test_error;
    test_back_to_back;
    test_addr;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
